// File: rtl/act_inbuffer.sv
// Ping-pong activation input buffer: loader fills one bank while the controller reads the other.
// Optional build macro ACT_ZERO_SKIP_EN drops all-zero words from the output stream.
module act_inbuffer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512,
    localparam int NIB   = DATA_W / 4,
    localparam int CNT_W = $clog2(NIB + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              ping_pong_write,
    input  logic              ping_pong_read,
    output logic              finished,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              tile_reset,
    output logic              act_valid,
    output logic [DATA_W-1:0] act_data,
    output logic [NIB-1:0]    act_nz_mask,
    output logic [CNT_W-1:0]  act_nz_cnt,
    output logic              act_zero,
    output logic              act_tile_start,
    output logic              overflow_err
);
    typedef enum logic {W_FILL, W_DONE} wstate_t;

    wstate_t           state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              wbank_q, wbank_d;
    logic              fin_q, fin_d;
    logic              ovf_q, ovf_d;
    logic              rdy_c, we_c;

    logic [DATA_W-1:0] mem [0:2*DEPTH-1];
    logic [DATA_W-1:0] rdata_q;
    logic              v1_q, ts1_q, tsflag_q;
    logic              vld_q, ts_q, zero_q;
    logic [DATA_W-1:0] data_q;
    logic [NIB-1:0]    mask_q, mask_c;
    logic [CNT_W-1:0]  cnt_q, cnt_c;
    logic              rzero_c;

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        wbank_d = wbank_q;
        fin_d   = 1'b0;
        ovf_d   = ovf_q;
        rdy_c   = 1'b0;
        we_c    = 1'b0;
        case (state_q)
            W_FILL: begin
                rdy_c = (ping_pong_write != ping_pong_read);
                if (wr_valid && rdy_c) begin
                    we_c    = 1'b1;
                    waddr_d = waddr_q + 1'b1;
                    if (wr_last || waddr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = W_DONE;
                        fin_d   = 1'b1;
                        wbank_d = ping_pong_write;
                        if (!wr_last) ovf_d = 1'b1;
                    end
                end
            end
            W_DONE: begin
                // Refill only once the controller has swapped the write bank.
                if (ping_pong_write != wbank_q) begin
                    state_d = W_FILL;
                    waddr_d = '0;
                end
            end
            default: state_d = W_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= W_FILL;
            waddr_q <= '0;
            wbank_q <= 1'b0;
            fin_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            wbank_q <= wbank_d;
            fin_q   <= fin_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we_c) mem[{ping_pong_write, waddr_q}] <= wr_data;
        if (rd_en) rdata_q <= mem[{ping_pong_read, rd_addr}];
    end

    always_comb begin
        mask_c = '0;
        cnt_c  = '0;
        for (int i = 0; i < NIB; i++) begin
            mask_c[i] = |rdata_q[4*i +: 4];
            cnt_c     = cnt_c + CNT_W'(mask_c[i]);
        end
        rzero_c = ~|mask_c;
    end

`ifdef ACT_ZERO_SKIP_EN
    logic carry_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q     <= 1'b0;
            ts1_q    <= 1'b0;
            tsflag_q <= 1'b1;
            vld_q    <= 1'b0;
            ts_q     <= 1'b0;
            zero_q   <= 1'b0;
            data_q   <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
`ifdef ACT_ZERO_SKIP_EN
            carry_q  <= 1'b0;
`endif
        end else begin
            v1_q  <= rd_en;
            ts1_q <= rd_en & (tsflag_q | tile_reset);
            if (tile_reset)  tsflag_q <= ~rd_en;
            else if (rd_en)  tsflag_q <= 1'b0;
            data_q <= rdata_q;
            mask_q <= mask_c;
            cnt_q  <= cnt_c;
            // tile_reset kills the word currently between RAM and output.
`ifdef ACT_ZERO_SKIP_EN
            vld_q  <= v1_q & ~tile_reset & ~rzero_c;
            ts_q   <= v1_q & ~tile_reset & ~rzero_c & (ts1_q | carry_q);
            zero_q <= 1'b0;
            if (tile_reset) carry_q <= 1'b0;
            else if (v1_q)  carry_q <= rzero_c & (carry_q | ts1_q);
`else
            vld_q  <= v1_q & ~tile_reset;
            ts_q   <= v1_q & ~tile_reset & ts1_q;
            zero_q <= v1_q & ~tile_reset & rzero_c;
`endif
        end
    end

    assign wr_ready       = rdy_c & rst;
    assign finished       = fin_q;
    assign overflow_err   = ovf_q;
    assign act_valid      = vld_q;
    assign act_data       = data_q;
    assign act_nz_mask    = mask_q;
    assign act_nz_cnt     = cnt_q;
    assign act_zero       = zero_q;
    assign act_tile_start = ts_q;
endmodule

// File: tb/tb_act_inbuffer.sv
// Bench for act_inbuffer: random words checked against a per-bank array model.
module tb_act_inbuffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0, wr_last = 1'b0;
    logic [63:0] wr_data = '0;
    logic        wr_ready;
    logic        pw = 1'b0, pr = 1'b1;
    logic        finished;
    logic        rd_en = 1'b0, tile_reset = 1'b0;
    logic [8:0]  rd_addr = '0;
    logic        act_valid, act_zero, act_tile_start, overflow_err;
    logic [63:0] act_data;
    logic [15:0] act_nz_mask;
    logic [4:0]  act_nz_cnt;

    int checks = 0;
    int errors = 0;

    logic [63:0] mdl [0:1023];

    logic [8:0]  rq_addr [0:19];
    logic        rq_trst [0:19];
    logic        c_vld [0:21], c_ts [0:21], c_zero [0:21];
    logic [63:0] c_data [0:21];
    logic [15:0] c_mask [0:21];
    logic [4:0]  c_cnt [0:21];
    logic [63:0] wq [0:15];
    logic        c_rdy [0:17], c_fin [0:17];

    act_inbuffer dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready), .ping_pong_write(pw), .ping_pong_read(pr), .finished(finished),
        .rd_en(rd_en), .rd_addr(rd_addr), .tile_reset(tile_reset), .act_valid(act_valid),
        .act_data(act_data), .act_nz_mask(act_nz_mask), .act_nz_cnt(act_nz_cnt),
        .act_zero(act_zero), .act_tile_start(act_tile_start), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mask(input logic [63:0] w);
        logic [15:0] m = '0;
        for (int i = 0; i < 16; i++) m[i] = (((w >> (4 * i)) & 64'hF) != 0);
        return m;
    endfunction

    function automatic logic [4:0] ref_cnt(input logic [63:0] w);
        int n = 0;
        for (int i = 0; i < 16; i++) if (((w >> (4 * i)) & 64'hF) != 0) n++;
        return 5'(n);
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Drives n reads (addresses/tile_reset from rq_*) and captures outputs for n+2 slots.
    task automatic do_reads(input int n);
        for (int k = 0; k < n + 2; k++) begin
            @(posedge clk); #1;
            rd_en      = (k < n);
            rd_addr    = (k < n) ? rq_addr[k] : 9'd0;
            tile_reset = (k < n) ? rq_trst[k] : 1'b0;
            @(negedge clk);
            c_vld[k] = act_valid; c_data[k] = act_data; c_mask[k] = act_nz_mask;
            c_cnt[k] = act_nz_cnt; c_ts[k] = act_tile_start; c_zero[k] = act_zero;
        end
        rd_en = 1'b0; tile_reset = 1'b0;
    endtask

    // Drives n words from wq (wr_last on word n-1) and captures ready/finished for n+2 slots.
    task automatic do_writes(input int n);
        for (int k = 0; k < n + 2; k++) begin
            @(posedge clk); #1;
            wr_valid = (k < n);
            wr_data  = (k < n) ? wq[k] : 64'd0;
            wr_last  = (k == n - 1);
            @(negedge clk);
            c_rdy[k] = wr_ready; c_fin[k] = finished;
        end
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; pw = 1'b0; pr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wr_ready, finished, act_valid, act_zero, act_tile_start, overflow_err} !== 6'b0 ||
            act_data !== 64'd0 || act_nz_mask !== 16'd0 || act_nz_cnt !== 5'd0) begin
            errors++;
            $display("FAIL reset: rdy=%b fin=%b vld=%b z=%b ts=%b ovf=%b data=%h mask=%h cnt=%0d, required all 0",
                     wr_ready, finished, act_valid, act_zero, act_tile_start, overflow_err,
                     act_data, act_nz_mask, act_nz_cnt);
        end
        @(posedge clk); #1; rst = 1'b1;
    endtask

    task automatic test_write();
        wq[0] = 64'h0000_0000_0000_F001;
        for (int i = 1; i < 4; i++) wq[i] = rnd64();
        do_writes(4);
        for (int i = 0; i < 4; i++) mdl[i] = wq[i];
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (c_rdy[k] !== (k < 4) || c_fin[k] !== (k == 4)) begin
                errors++;
                $display("FAIL write slot %0d: wr_ready=%b finished=%b, required %b %b",
                         k, c_rdy[k], c_fin[k], k < 4, k == 4);
            end
        end
        checks++;
        if (overflow_err !== 1'b0) begin
            errors++; $display("FAIL ovf_after_last: got %b required 0", overflow_err);
        end
    endtask

    task automatic test_read();
        @(posedge clk); #1; pw = 1'b1; pr = 1'b0;
        for (int i = 0; i < 4; i++) begin rq_addr[i] = 9'(i); rq_trst[i] = 1'b0; end
        do_reads(4);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (c_vld[k] !== 1'b0) begin
                errors++; $display("FAIL read_latency slot %0d: act_valid=%b required 0", k, c_vld[k]);
            end
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (c_vld[j+2] !== 1'b1 || c_data[j+2] !== mdl[j] || c_mask[j+2] !== ref_mask(mdl[j]) ||
                c_cnt[j+2] !== ref_cnt(mdl[j]) || c_ts[j+2] !== (j == 0)) begin
                errors++;
                $display("FAIL read word %0d: vld=%b data=%h mask=%h cnt=%0d ts=%b, required 1 %h %h %0d %b",
                         j, c_vld[j+2], c_data[j+2], c_mask[j+2], c_cnt[j+2], c_ts[j+2],
                         mdl[j], ref_mask(mdl[j]), ref_cnt(mdl[j]), j == 0);
            end
        end
        checks++;
        if (c_mask[2] !== 16'h0009 || c_cnt[2] !== 5'd2) begin
            errors++; $display("FAIL mask_f001: mask=%h cnt=%0d required 0009 2", c_mask[2], c_cnt[2]);
        end
    endtask

    task automatic test_collision();
        @(posedge clk); #1; pw = 1'b0; pr = 1'b0;
        for (int i = 0; i < 4; i++) wq[i] = rnd64();
        do_writes(4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (c_rdy[k] !== 1'b0) begin
                errors++; $display("FAIL collision_ready slot %0d: got %b required 0", k, c_rdy[k]);
            end
        end
        for (int i = 0; i < 4; i++) begin rq_addr[i] = 9'(i); rq_trst[i] = 1'b0; end
        do_reads(4);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (c_vld[j+2] !== 1'b1 || c_data[j+2] !== mdl[j]) begin
                errors++;
                $display("FAIL collision_readback %0d: vld=%b data=%h required 1 %h",
                         j, c_vld[j+2], c_data[j+2], mdl[j]);
            end
        end
    endtask

    task automatic test_overflow();
        int fin_cnt = 0, rdy_bad = 0;
        logic [63:0] w;
        @(posedge clk); #1; pw = 1'b1; pr = 1'b0;
        for (int k = 0; k < 515; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            w = rnd64();
            wr_valid = (k < 512); wr_data = w; wr_last = 1'b0;
            if (k < 512) mdl[512 + k] = w;
            @(negedge clk);
            if (wr_ready !== (k < 512)) rdy_bad++;
            if (finished === 1'b1) begin
                fin_cnt++;
                checks++;
                if (k != 512) begin
                    errors++; $display("FAIL overflow_fin_slot: pulse at %0d required 512", k);
                end
            end
        end
        wr_valid = 1'b0;
        checks++;
        if (rdy_bad != 0) begin
            errors++; $display("FAIL overflow_ready: %0d bad slots required 0", rdy_bad);
        end
        checks++;
        if (fin_cnt != 1) begin
            errors++; $display("FAIL overflow_fin_count: got %0d required 1", fin_cnt);
        end
        checks++;
        if (overflow_err !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL overflow_flag: ovf=%b rdy=%b required 1 0", overflow_err, wr_ready);
        end
        @(posedge clk); #1; pr = 1'b1;
        rq_addr[0] = 9'd0; rq_addr[1] = 9'd511;
        for (int i = 0; i < 8; i++) begin
            if (i > 1) rq_addr[i] = 9'($urandom_range(0, 511));
            rq_trst[i] = 1'b0;
        end
        do_reads(8);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (c_vld[j+2] !== 1'b1 || c_data[j+2] !== mdl[512 + rq_addr[j]] ||
                c_cnt[j+2] !== ref_cnt(mdl[512 + rq_addr[j]])) begin
                errors++;
                $display("FAIL bank1_read addr %0d: vld=%b data=%h cnt=%0d required 1 %h %0d", rq_addr[j],
                         c_vld[j+2], c_data[j+2], c_cnt[j+2], mdl[512 + rq_addr[j]],
                         ref_cnt(mdl[512 + rq_addr[j]]));
            end
        end
    endtask

    task automatic test_tile_reset();
        rq_addr[0] = 9'($urandom_range(0, 511)); rq_trst[0] = 1'b0;
        rq_addr[1] = 9'($urandom_range(0, 511)); rq_trst[1] = 1'b1;
        do_reads(2);
        checks++;
        if (c_vld[2] !== 1'b0) begin
            errors++; $display("FAIL tile_reset_kill: act_valid=%b required 0", c_vld[2]);
        end
        checks++;
        if (c_vld[3] !== 1'b1 || c_ts[3] !== 1'b1 || c_data[3] !== mdl[512 + rq_addr[1]]) begin
            errors++;
            $display("FAIL tile_reset_start: vld=%b ts=%b data=%h required 1 1 %h",
                     c_vld[3], c_ts[3], c_data[3], mdl[512 + rq_addr[1]]);
        end
    endtask

    task automatic test_zero_word();
        @(posedge clk); #1; pw = 1'b0; pr = 1'b1;
        for (int i = 0; i < 5; i++) wq[i] = rnd64() | 64'h1;
        wq[5] = 64'd0;
        do_writes(6);
        for (int i = 0; i < 6; i++) mdl[i] = wq[i];
        checks++;
        if (c_fin[6] !== 1'b1 || c_rdy[0] !== 1'b1) begin
            errors++; $display("FAIL zero_load: fin=%b rdy0=%b required 1 1", c_fin[6], c_rdy[0]);
        end
        @(posedge clk); #1; pw = 1'b1; pr = 1'b0;
        rq_addr[0] = 9'd5; rq_trst[0] = 1'b1;
        rq_addr[1] = 9'd4; rq_trst[1] = 1'b0;
        do_reads(2);
`ifdef ACT_ZERO_SKIP_EN
        checks++;
        if (c_vld[2] !== 1'b0) begin
            errors++; $display("FAIL zero_skip: act_valid=%b required 0", c_vld[2]);
        end
        checks++;
        if (c_vld[3] !== 1'b1 || c_data[3] !== mdl[4] || c_ts[3] !== 1'b1 || c_zero[3] !== 1'b0) begin
            errors++;
            $display("FAIL zero_skip_next: vld=%b data=%h ts=%b z=%b required 1 %h 1 0",
                     c_vld[3], c_data[3], c_ts[3], c_zero[3], mdl[4]);
        end
`else
        checks++;
        if (c_vld[2] !== 1'b1 || c_zero[2] !== 1'b1 || c_cnt[2] !== 5'd0 || c_mask[2] !== 16'd0 ||
            c_ts[2] !== 1'b1) begin
            errors++;
            $display("FAIL zero_word: vld=%b z=%b cnt=%0d mask=%h ts=%b required 1 1 0 0000 1",
                     c_vld[2], c_zero[2], c_cnt[2], c_mask[2], c_ts[2]);
        end
        checks++;
        if (c_vld[3] !== 1'b1 || c_data[3] !== mdl[4] || c_ts[3] !== 1'b0 || c_zero[3] !== 1'b0) begin
            errors++;
            $display("FAIL zero_next: vld=%b data=%h ts=%b z=%b required 1 %h 0 0",
                     c_vld[3], c_data[3], c_ts[3], c_zero[3], mdl[4]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_collision();
        test_overflow();
        test_tile_reset();
        test_zero_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/act_inbuffer.md
Name: act_inbuffer

Overview:
Ping-pong activation input buffer: two banks of packed 4-bit activations, 16 per 64-bit word.
- Write side fills one bank from the loader stream. It pulses `finished` to the activation controller when the tile load completes.
- Read side serves the controller's `addrout`/`enout` stream from the other bank.
- Each read word is annotated with a per-nibble nonzero mask and count, feeding the sparse PE array.

Parameters:
DATA_W, 64, read/write word width (16 x 4-bit activations)
ADDR_W, 9, bank address width
DEPTH, 512, words per bank (2**ADDR_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
wr_valid  in  1  loader word valid
wr_data  in  64  loader word; nibble i = wr_data[4i+3:4i]
wr_last  in  1  qualifies last word of tile load
wr_ready  out  1  buffer accepts word this cycle
ping_pong_write  in  1  bank selected for writing
ping_pong_read  in  1  bank selected for reading
finished  out  1  one-cycle pulse: tile load complete
rd_en  in  1  read request (controller enout)
rd_addr  in  9  read word address (controller addrout)
tile_reset  in  1  tile boundary from controller (reset output)
act_valid  out  1  output word valid
act_data  out  64  read word
act_nz_mask  out  16  bit i = (nibble i != 0)
act_nz_cnt  out  5  popcount of act_nz_mask, 0..16
act_zero  out  1  act_data == 0
act_tile_start  out  1  first valid word after tile_reset
overflow_err  out  1  sticky: bank filled without wr_last

Behaviour:
Reset (rst=0, async):
- All outputs 0.
- Write FSM to W_FILL, write address 0.
- Read pipeline valids cleared; tile_start flag set to 1.

Write FSM states: W_FILL, W_DONE.
- W_FILL: wr_ready = (ping_pong_write != ping_pong_read).
  - Transfer when wr_valid & wr_ready: store at wr_addr in bank ping_pong_write, then wr_addr += 1.
  - On a transfer with wr_last=1, or at wr_addr == DEPTH-1: go to W_DONE and pulse finished in the next cycle.
  - At DEPTH-1 without wr_last: also set overflow_err (cleared only by rst).
- W_DONE: wr_ready = 0. When ping_pong_write differs from its value latched on entry, go to W_FILL with wr_addr = 0.
- finished is exactly one cycle wide per load.
- Bank collision (write bank == read bank): wr_ready = 0; no RAM write occurs.

Read pipeline, latency 2, no backpressure:
- Cycle N: rd_en=1 reads bank ping_pong_read at rd_addr. Bank select is sampled in cycle N.
- Cycle N+1: registered RAM data.
- Cycle N+2: act_valid=1 with act_data, mask, count and zero registered together.
- One word per cycle sustained.
- act_tile_start = 1 on the first output of the first rd_en accepted after tile_reset, then 0.

tile_reset:
- Clears in-flight valids (stages N+1 and N+2 of earlier reads produce no output).
- Sets the tile_start flag.
- rd_en in the same cycle as tile_reset is accepted and marked tile_start.

Simultaneous write and read to different banks in the same cycle: independent, both proceed.
Read of an address never written: returns RAM contents. No error raised.

Optional Feature:
ACT_ZERO_SKIP_EN
- Defined: words with act_data == 0 are suppressed at stage N+2 (act_valid stays 0).
  - tile_start carries to the next nonzero word.
  - act_zero is tied 0.
- Undefined: all words are emitted; act_zero flags all-zero words.

Test Plan:
1. Reset, then write 4 words (wr_last on word 4) to bank 0 with ping_pong_read=1 -> wr_ready high for 4 cycles; finished pulses once one cycle after word 4; wr_ready then 0.
2. Toggle ping_pong_write to 1 and ping_pong_read to 0; rd_en at addr 0..3 on consecutive cycles -> act_valid at cycles +2..+5 with the stored data. Word 0x0000_0000_0000_F001 -> mask 0x0009, cnt 2.
3. ping_pong_write == ping_pong_read with wr_valid held -> wr_ready 0; bank contents unchanged on readback.
4. Write 512 words with no wr_last -> overflow_err=1; finished pulses once; state W_DONE.
5. tile_reset in the cycle after rd_en, together with a new rd_en -> first read produces no output; second read emerges with act_tile_start=1.
6. Zero word 0 at addr 5, read it -> without ACT_ZERO_SKIP_EN: act_valid=1, act_zero=1, cnt 0. With the macro: act_valid stays 0.
